memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Responder end of the core memory interface.
- Accepts read and write commands from the core's memory initiator and serves them from an on-chip word RAM.
- Returns a one-cycle memory_valid completion after a fixed, parameterised latency.
- Sits between the core and the instruction/data store in the SoC top; one request is outstanding at a time.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the RAM; must be a power of two.
- LATENCY, 1: cycles from the acceptance edge to the completion cycle; legal values 1..15.
- BASE_ADDRESS, 0: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memory_enable  in  1  request strobe from the core.
- memory_command  in  1  0 = read, 1 = write; sampled at acceptance.
- read_memory_address  in  32  byte address for reads; bits [1:0] ignored.
- write_memory_address  in  32  byte address for writes; bits [1:0] ignored.
- write_memory_data  in  32  write data.
- write_memory_mask  in  32  per-bit write enable; 1 = bit written.
- memory_ready  out  1  responder can accept a request this cycle.
- memory_valid  out  1  one-cycle completion pulse for the accepted request.
- read_memory_data  out  32  read result; held until the next read completes.
- memory_fault  out  1  high together with memory_valid when the completed access was out of range.

Behaviour:
- Reset (reset low, asynchronous): memory_ready=0, memory_valid=0, read_memory_data=0, memory_fault=0, state=IDLE, latency counter=0. RAM contents are not reset.
- First rising edge after reset deasserts: memory_ready goes to 1.
- Acceptance: a rising edge with memory_enable=1 and memory_ready=1. memory_enable while memory_ready=0 is ignored; no queuing.
- States:
  - IDLE: memory_ready=1. On acceptance, go to DONE if LATENCY==1, otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: memory_ready=0. Counter decrements each edge; at counter==1 the next edge enters DONE.
  - DONE: memory_valid=1 and memory_ready=0 for exactly one cycle, then IDLE.
- Timing: memory_valid is high in the LATENCY-th cycle after the acceptance edge. Peak throughput is one request per LATENCY+1 cycles.
- Index: word index = (addr - BASE_ADDRESS) >> 2.
- In range: (addr - BASE_ADDRESS) < DEPTH_WORDS*4, computed unsigned in 32 bits so addresses below the base wrap and count as out of range.
- Write: the command, write address, write data and mask are captured at the acceptance edge. The RAM is updated on that same edge as new = (old & ~mask) | (data & mask). Out of range: no RAM change and memory_fault=1 in DONE. read_memory_data is unchanged by writes.
- Read: the address is captured at acceptance. read_memory_data is loaded on the edge entering DONE with the RAM word at that index, or 0 with memory_fault=1 if out of range.
- Read-after-write ordering: requests are serialised, so a read accepted after a write's completion always sees the written data.
- Mask 0x00000000 on a write: completes normally, RAM unchanged.
- Reset asserted mid-operation (WAIT or DONE): the request is aborted and no memory_valid is emitted. A write accepted before the reset remains committed.
- memory_fault is 0 whenever memory_valid is 0.

Decomposition:
- Package memory_pkg holds:
  - MEM_READ=1'b0 and MEM_WRITE=1'b1
  - enum responder_state_t {IDLE, WAIT, DONE}
  - a LATENCY counter width constant of 4
- Sub-module word_ram: synchronous single-port DEPTH_WORDS x 32 RAM with a per-bit write mask and registered read. The responder FSM drives its address, enable and mask.

Test Plan:
- Reset release, LATENCY=1: hold reset low 3 cycles then release -> memory_ready=0 in the first cycle after release, 1 from the next edge; memory_valid=0 throughout.
- Write then read, LATENCY=1: write 0x00000010 data 0xDEADBEEF mask 0xFFFFFFFF, then read 0x00000010 -> each request has memory_valid exactly one cycle after acceptance; read_memory_data=0xDEADBEEF; memory_fault=0.
- Masked write: store 0x11223344 at 0x20, then write data 0xAABBCCDD mask 0x0000FF00, then read 0x20 -> 0x1122CC44.
- LATENCY=3, back-to-back reads of 0x0 and 0x4 with memory_enable held high -> memory_valid 3 cycles after each acceptance; memory_ready low for 3 cycles per request; second acceptance 4 cycles after the first.
- Out of range, DEPTH_WORDS=4096: read 0x00004000 -> memory_valid=1, memory_fault=1, read_memory_data=0. Write 0x00004000 -> memory_fault=1, and word 0 reads back unchanged.
- Reset during WAIT, LATENCY=4: accept a write to 0x8 with data 0x5A5A5A5A, assert reset 2 cycles later -> no memory_valid pulse; after release, a read of 0x8 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared command encodings, FSM states and counter width for the memory responder.
package memory_pkg;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam int   CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } responder_state_t;
endpackage

// File: rtl/word_ram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-bit write mask and registered read.
// Contents are never reset; only the read register is cleared.
module word_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   mask,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/memory_responder.sv
// Memory responder: one outstanding request, completion pulse LATENCY cycles after acceptance.
// Writes commit on the acceptance edge; reads load the RAM register on the edge entering DONE.
module memory_responder #(
  parameter int          DEPTH_WORDS  = 4096,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] read_memory_address,
  input  logic [31:0] write_memory_address,
  input  logic [31:0] write_memory_data,
  input  logic [31:0] write_memory_mask,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_memory_data,
  output logic        memory_fault
);
  import memory_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  responder_state_t state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ready_q;
  logic             cmd_q;
  logic             fault_q;
  logic             zero_q;
  logic [AW-1:0]    rd_index_q;

  logic [31:0]      rd_off, wr_off;
  logic             rd_ok, wr_ok;
  logic [AW-1:0]    rd_index, wr_index;
  logic             accept, enter_done, cur_cmd, cur_rd_ok;
  logic             ram_en, ram_we, ram_re;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_rdata;

  // Unsigned subtraction makes addresses below the base wrap to huge offsets.
  assign rd_off   = read_memory_address - BASE_ADDRESS;
  assign wr_off   = write_memory_address - BASE_ADDRESS;
  assign rd_ok    = (rd_off >> (AW + 2)) == 32'h0;
  assign wr_ok    = (wr_off >> (AW + 2)) == 32'h0;
  assign rd_index = rd_off[AW+1:2];
  assign wr_index = wr_off[AW+1:2];

  assign accept     = memory_enable && ready_q;
  assign enter_done = (state == IDLE && accept && LATENCY == 1) ||
                      (state == WAIT && count == CNT_W'(1));

  // With LATENCY==1 the read happens on the acceptance edge itself, straight from the inputs.
  assign cur_cmd   = (state == IDLE) ? memory_command : cmd_q;
  assign cur_rd_ok = (state == IDLE) ? rd_ok : !fault_q;

  assign ram_we   = accept && (memory_command == MEM_WRITE) && wr_ok;
  assign ram_re   = enter_done && (cur_cmd == MEM_READ) && cur_rd_ok;
  assign ram_en   = ram_we || ram_re;
  assign ram_addr = ram_we ? wr_index : ((state == IDLE) ? rd_index : rd_index_q);

  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            count_next = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_next = count - 1'b1;
        if (count == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        count_next = '0;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      ready_q    <= 1'b0;
      cmd_q      <= MEM_READ;
      fault_q    <= 1'b0;
      zero_q     <= 1'b0;
      rd_index_q <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ready_q <= (state_next == IDLE);
      if (accept) begin
        cmd_q      <= memory_command;
        rd_index_q <= rd_index;
        fault_q    <= (memory_command == MEM_WRITE) ? !wr_ok : !rd_ok;
      end
      // An out-of-range read shows zero until the next read completes.
      if (enter_done && cur_cmd == MEM_READ) begin
        zero_q <= !cur_rd_ok;
      end
    end
  end

  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(write_memory_data),
    .mask (write_memory_mask),
    .rdata(ram_rdata)
  );

  assign memory_ready     = ready_q;
  assign memory_valid     = (state == DONE);
  assign memory_fault     = (state == DONE) && fault_q;
  assign read_memory_data = zero_q ? 32'h0 : ram_rdata;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three configurations (LATENCY 1/3/4, different bases and depths)
// driven by directed and random requests against a word-map reference model.
module tb_memory_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        en    [3];
  logic        cmd   [3];
  logic [31:0] raddr [3];
  logic [31:0] waddr [3];
  logic [31:0] wdata [3];
  logic [31:0] wmask [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic        flt   [3];
  logic [31:0] rdat  [3];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl [longint];
  logic [31:0] last_rd [3];
  bit          rd_known [3];

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .BASE_ADDRESS(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset), .memory_enable(en[0]), .memory_command(cmd[0]),
    .read_memory_address(raddr[0]), .write_memory_address(waddr[0]),
    .write_memory_data(wdata[0]), .write_memory_mask(wmask[0]),
    .memory_ready(rdy[0]), .memory_valid(vld[0]), .read_memory_data(rdat[0]), .memory_fault(flt[0]));

  memory_responder #(.DEPTH_WORDS(256), .LATENCY(3), .BASE_ADDRESS(32'h0000_1000)) u1 (
    .clk(clk), .reset(reset), .memory_enable(en[1]), .memory_command(cmd[1]),
    .read_memory_address(raddr[1]), .write_memory_address(waddr[1]),
    .write_memory_data(wdata[1]), .write_memory_mask(wmask[1]),
    .memory_ready(rdy[1]), .memory_valid(vld[1]), .read_memory_data(rdat[1]), .memory_fault(flt[1]));

  memory_responder #(.DEPTH_WORDS(64), .LATENCY(4), .BASE_ADDRESS(32'h0000_0000)) u2 (
    .clk(clk), .reset(reset), .memory_enable(en[2]), .memory_command(cmd[2]),
    .read_memory_address(raddr[2]), .write_memory_address(waddr[2]),
    .write_memory_data(wdata[2]), .write_memory_mask(wmask[2]),
    .memory_ready(rdy[2]), .memory_valid(vld[2]), .read_memory_data(rdat[2]), .memory_fault(flt[2]));

  function automatic int lat(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] base(input int d);
    return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int depth(input int d);
    return (d == 0) ? 4096 : (d == 1) ? 256 : 64;
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base(d);
    return {32'h0, off} < (64'(depth(d)) * 64'd4);
  endfunction

  function automatic longint key(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base(d);
    return longint'((64'(d) << 32) | {32'h0, off >> 2});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input int d, input logic c, input logic [31:0] a,
                     input logic [31:0] dat, input logic [31:0] m, input string tag);
    bit got;
    bit hit;
    int k;
    longint kk;
    @(posedge clk); #1;
    cmd[d] = c; wdata[d] = dat; wmask[d] = m; en[d] = 1'b1;
    if (c) begin waddr[d] = a; raddr[d] = $urandom; end
    else   begin raddr[d] = a; waddr[d] = $urandom; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy[d];
    end
    check({tag, "/ready"}, 32'(got), 32'd1);
    if (!got) begin
      en[d] = 1'b0;
      return;
    end
    @(posedge clk); #1 en[d] = 1'b0;
    hit = in_rng(d, a);
    kk  = key(d, a);
    if (c && hit) begin
      if (mdl.exists(kk)) mdl[kk] = (mdl[kk] & ~m) | (dat & m);
      else if (m == 32'hFFFF_FFFF) mdl[kk] = dat;
    end
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      k++;
      got = vld[d];
      if (!got) begin
        check({tag, "/busy_rdy"}, 32'(rdy[d]), 32'd0);
        check({tag, "/busy_flt"}, 32'(flt[d]), 32'd0);
      end
    end
    check({tag, "/latency"}, k, lat(d));
    check({tag, "/fault"}, 32'(flt[d]), 32'(!hit));
    if (!c) begin
      if (!hit) begin last_rd[d] = 32'h0; rd_known[d] = 1'b1; end
      else if (mdl.exists(kk)) begin last_rd[d] = mdl[kk]; rd_known[d] = 1'b1; end
      else rd_known[d] = 1'b0;
    end
    if (rd_known[d]) check({tag, "/rdata"}, rdat[d], last_rd[d]);
    @(negedge clk);
    check({tag, "/vld_end"}, 32'(vld[d]), 32'd0);
    check({tag, "/rdy_end"}, 32'(rdy[d]), 32'd1);
    check({tag, "/flt_end"}, 32'(flt[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] m;
    int d;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; cmd[i] = 1'b0; raddr[i] = '0; waddr[i] = '0;
      wdata[i] = '0; wmask[i] = '0; last_rd[i] = '0; rd_known[i] = 1'b1;
    end

    // Reset held for three cycles, released mid-cycle.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d/rdy", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst%0d/vld", i), 32'(vld[i]), 32'd0);
      check($sformatf("rst%0d/flt", i), 32'(flt[i]), 32'd0);
      check($sformatf("rst%0d/rdat", i), rdat[i], 32'h0);
    end
    reset = 1'b1;
    #1;
    check("release/rdy_first_cycle", 32'(rdy[0]), 32'd0);
    check("release/vld_first_cycle", 32'(vld[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("release%0d/rdy", i), 32'(rdy[i]), 32'd1);
      check($sformatf("release%0d/vld", i), 32'(vld[i]), 32'd0);
    end

    // Known contents for the 16-word window used by everything below.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 16; w++)
        req(i, 1'b1, base(i) + 32'(4 * w), $urandom, 32'hFFFF_FFFF, $sformatf("init%0d_%0d", i, w));

    req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, "wr10");
    req(0, 1'b0, 32'h10, 32'h0, 32'h0, "rd10");
    check("rd10/const", rdat[0], 32'hDEAD_BEEF);

    req(0, 1'b1, 32'h20, 32'h1122_3344, 32'hFFFF_FFFF, "wr20");
    req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 32'h0000_FF00, "wr20m");
    req(0, 1'b0, 32'h23, 32'h0, 32'h0, "rd20");
    check("rd20/const", rdat[0], 32'h1122_CC44);

    req(0, 1'b0, 32'h4000, 32'h0, 32'h0, "rd_oor");
    check("rd_oor/const", rdat[0], 32'h0);
    req(0, 1'b1, 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wr_oor");
    req(0, 1'b0, 32'h0, 32'h0, 32'h0, "rd0_after_oor");
    req(1, 1'b0, 32'h0FFC, 32'h0, 32'h0, "rd_below_base");

    req(1, 1'b1, 32'h1008, 32'h0BAD_F00D, 32'h0, "wr_mask0");
    req(1, 1'b0, 32'h1008, 32'h0, 32'h0, "rd_mask0");

    // Back-to-back reads with enable held high on the LATENCY=3 instance.
    @(posedge clk); #1;
    cmd[1] = 1'b0; raddr[1] = 32'h1000; en[1] = 1'b1;
    @(negedge clk);
    check("b2b/ready0", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1 raddr[1] = 32'h1004;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check($sformatf("b2b/vld_c%0d", n), 32'(vld[1]), 32'(n == 3 || n == 7));
      check($sformatf("b2b/rdy_c%0d", n), 32'(rdy[1]), 32'(n == 4 || n == 8));
      if (n == 3) check("b2b/rdata0", rdat[1], mdl[key(1, 32'h1000)]);
      if (n == 7) check("b2b/rdata4", rdat[1], mdl[key(1, 32'h1004)]);
      if (n == 4) begin
        @(posedge clk); #1 en[1] = 1'b0;
      end
    end
    last_rd[1] = mdl[key(1, 32'h1004)];

    // Reset during WAIT on the LATENCY=4 instance; the write must stay committed.
    @(posedge clk); #1;
    cmd[2] = 1'b1; waddr[2] = 32'h8; wdata[2] = 32'h5A5A_5A5A; wmask[2] = 32'hFFFF_FFFF; en[2] = 1'b1;
    @(negedge clk);
    check("rstwait/ready", 32'(rdy[2]), 32'd1);
    @(posedge clk); #1 en[2] = 1'b0;
    mdl[key(2, 32'h8)] = 32'h5A5A_5A5A;
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("rstwait/no_vld%0d", n), 32'(vld[2]), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin last_rd[i] = 32'h0; rd_known[i] = 1'b1; end
    @(negedge clk);
    check("rstwait/vld_after", 32'(vld[2]), 32'd0);
    check("rstwait/rdat_after", rdat[2], 32'h0);
    req(2, 1'b0, 32'h8, 32'h0, 32'h0, "rstwait_rd8");
    check("rstwait_rd8/const", rdat[2], 32'h5A5A_5A5A);

    for (int t = 0; t < 150; t++) begin
      d = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0:       a = base(d) - 32'(4 * $urandom_range(1, 4));
        1:       a = base(d) + 32'(depth(d) * 4) + 32'(4 * $urandom_range(0, 3));
        default: a = base(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       m = 32'hFFFF_FFFF;
        1:       m = 32'h0;
        default: m = $urandom;
      endcase
      req(d, 1'($urandom_range(0, 1)), a, $urandom, m, $sformatf("rnd%0d_d%0d", t, d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
